// File: rtl/hilo_unit.sv
// HI/LO pipeline stage: carries hiloresult through M and W, commits to architectural HI/LO, forwards to execute.
// Latency: forwarded from M at N+1, commit at N+2, architectural at N+3; stall_m freezes M/W/arch, flush_m kills M.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           hilo_we_e,
  input  logic [2*WIDTH-1:0]   hiloresult_e,
  input  logic                 stall_e,
  input  logic                 stall_m,
  input  logic                 flush_m,
  output logic [WIDTH-1:0]     hi_e,
  output logic [WIDTH-1:0]     lo_e,
  output logic [WIDTH-1:0]     hi_q,
  output logic [WIDTH-1:0]     lo_q,
  output logic [1:0]           commit_w
);

  logic [1:0]         we_m_q, we_m_d;
  logic [1:0]         we_w_q, we_w_d;
  logic [2*WIDTH-1:0] data_m_q, data_m_d;
  logic [2*WIDTH-1:0] data_w_q, data_w_d;
  logic [WIDTH-1:0]   hi_arch_q, hi_arch_d;
  logic [WIDTH-1:0]   lo_arch_q, lo_arch_d;

  // Flush outranks stall_m for M: the faulting instruction must die even while memory is held.
  always_comb begin
    we_m_d   = we_m_q;
    data_m_d = data_m_q;
    if (flush_m) begin
      we_m_d = 2'b00;
    end else if (!stall_m) begin
      if (stall_e) begin
        we_m_d = 2'b00;
      end else begin
        we_m_d   = hilo_we_e;
        data_m_d = hiloresult_e;
      end
    end
  end

  always_comb begin
    we_w_d   = we_w_q;
    data_w_d = data_w_q;
    if (!stall_m) begin
      if (flush_m) begin
        we_w_d = 2'b00;
      end else begin
        we_w_d   = we_m_q;
        data_w_d = data_m_q;
      end
    end
  end

  always_comb begin
    hi_arch_d = hi_arch_q;
    lo_arch_d = lo_arch_q;
    if (!stall_m) begin
      if (we_w_q[1]) hi_arch_d = data_w_q[2*WIDTH-1:WIDTH];
      if (we_w_q[0]) lo_arch_d = data_w_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_m_q    <= '0;
      we_w_q    <= '0;
      data_m_q  <= '0;
      data_w_q  <= '0;
      hi_arch_q <= '0;
      lo_arch_q <= '0;
    end else begin
      we_m_q    <= we_m_d;
      we_w_q    <= we_w_d;
      data_m_q  <= data_m_d;
      data_w_q  <= data_w_d;
      hi_arch_q <= hi_arch_d;
      lo_arch_q <= lo_arch_d;
    end
  end

  // Per-half forwarding, nearest producer first.
  assign hi_e = we_m_q[1] ? data_m_q[2*WIDTH-1:WIDTH] :
                we_w_q[1] ? data_w_q[2*WIDTH-1:WIDTH] : hi_arch_q;
  assign lo_e = we_m_q[0] ? data_m_q[WIDTH-1:0] :
                we_w_q[0] ? data_w_q[WIDTH-1:0] : lo_arch_q;

  assign hi_q     = hi_arch_q;
  assign lo_q     = lo_arch_q;
  assign commit_w = we_w_q & {2{~stall_m}};

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit; commits are checked against a queue of expected writes.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hilo_we_e;
  logic [63:0] hiloresult_e;
  logic        stall_e, stall_m, flush_m;
  logic [31:0] hi_e, lo_e, hi_q, lo_q;
  logic [1:0]  commit_w;

  hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .hilo_we_e(hilo_we_e), .hiloresult_e(hiloresult_e),
    .stall_e(stall_e), .stall_m(stall_m), .flush_m(flush_m),
    .hi_e(hi_e), .lo_e(lo_e), .hi_q(hi_q), .lo_q(lo_q), .commit_w(commit_w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  we;
    logic [63:0] data;
  } wr_t;

  wr_t         sb[$];
  int          passed = 0;
  int          fails  = 0;
  int          total  = 0;
  logic [1:0]  pend_we = 2'b00;
  logic [63:0] pend_data = 64'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [63:0] d,
                       input logic se, input logic sm, input logic fm);
    hilo_we_e    = we;
    hiloresult_e = d;
    stall_e      = se;
    stall_m      = sm;
    flush_m      = fm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] we, input logic [63:0] d);
    wr_t e;
    e.we   = we;
    e.data = d;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: each commit pops the oldest expected write; the arch value is checked a cycle later.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      pend_we = 2'b00;
    end else begin
      if (pend_we[1]) check("sb_hi_q", {32'd0, hi_q}, {32'd0, pend_data[63:32]});
      if (pend_we[0]) check("sb_lo_q", {32'd0, lo_q}, {32'd0, pend_data[31:0]});
      pend_we = 2'b00;
      if (commit_w != 2'b00) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_commit", {62'd0, commit_w}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_commit_we", {62'd0, commit_w}, {62'd0, e.we});
          pend_we   = e.we;
          pend_data = e.data;
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_hi_e", {32'd0, hi_e}, 64'd0);
    check("rst_lo_e", {32'd0, lo_e}, 64'd0);
    check("rst_hi_q", {32'd0, hi_q}, 64'd0);
    check("rst_lo_q", {32'd0, lo_q}, 64'd0);
    check("rst_commit_w", {62'd0, commit_w}, 64'd0);
    rst = 1'b1;

    // MTHI latency
    drive(2'b10, 64'h12345678_00000000, 1'b0, 1'b0, 1'b0);
    push(2'b10, 64'h12345678_00000000);
    tick();
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    check("mthi_fwd_hi_e", {32'd0, hi_e}, 64'h12345678);
    check("mthi_fwd_lo_e", {32'd0, lo_e}, 64'd0);
    tick();
    check("mthi_commit_w", {62'd0, commit_w}, 64'd2);
    tick();
    check("mthi_hi_q", {32'd0, hi_q}, 64'h12345678);
    check("mthi_lo_q", {32'd0, lo_q}, 64'd0);

    // MULT then MTLO back-to-back; MTLO's HI half must be ignored
    drive(2'b11, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 1'b0);
    push(2'b11, 64'hFFFFFFFF_FFFFFFFE);
    tick();
    drive(2'b01, 64'hDEADBEEF_A5A5A5A5, 1'b0, 1'b0, 1'b0);
    push(2'b01, 64'hDEADBEEF_A5A5A5A5);
    tick();
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    check("b2b_hi_e_from_w", {32'd0, hi_e}, 64'hFFFFFFFF);
    check("b2b_lo_e_from_m", {32'd0, lo_e}, 64'hA5A5A5A5);
    repeat (3) tick();
    check("b2b_hi_q", {32'd0, hi_q}, 64'hFFFFFFFF);
    check("b2b_lo_q", {32'd0, lo_q}, 64'hA5A5A5A5);

    // DIV held by stall_e: nothing may enter M until the divider is ready
    for (int i = 0; i < 33; i++) begin
      drive(2'b11, 64'h00000001_00000003, 1'b1, 1'b0, 1'b0);
      check("div_stall_hi_e", {32'd0, hi_e}, 64'hFFFFFFFF);
      check("div_stall_lo_e", {32'd0, lo_e}, 64'hA5A5A5A5);
      check("div_stall_commit", {62'd0, commit_w}, 64'd0);
      tick();
    end
    drive(2'b11, 64'h00000001_00000003, 1'b0, 1'b0, 1'b0);
    push(2'b11, 64'h00000001_00000003);
    tick();
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    check("div_fwd_hi_e", {32'd0, hi_e}, 64'h1);
    check("div_fwd_lo_e", {32'd0, lo_e}, 64'h3);
    tick();
    tick();
    check("div_hi_q", {32'd0, hi_q}, 64'h1);
    check("div_lo_q", {32'd0, lo_q}, 64'h3);

    // Restore 12345678/A5A5A5A5 before the flush case
    drive(2'b10, 64'h12345678_00000000, 1'b0, 1'b0, 1'b0);
    push(2'b10, 64'h12345678_00000000);
    tick();
    drive(2'b01, 64'h00000000_A5A5A5A5, 1'b0, 1'b0, 1'b0);
    push(2'b01, 64'h00000000_A5A5A5A5);
    tick();
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Flush kills MULT in M and the MTLO entering alongside it
    drive(2'b11, 64'h0BADF00D_CAFEBABE, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b01, 64'h00000000_11111111, 1'b0, 1'b0, 1'b1);
    check("flush_prefwd_hi_e", {32'd0, hi_e}, 64'h0BADF00D);
    tick();
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    check("flush_commit0", {62'd0, commit_w}, 64'd0);
    check("flush_hi_e", {32'd0, hi_e}, 64'h12345678);
    check("flush_lo_e", {32'd0, lo_e}, 64'hA5A5A5A5);
    tick();
    check("flush_commit1", {62'd0, commit_w}, 64'd0);
    tick();
    check("flush_hi_q", {32'd0, hi_q}, 64'h12345678);
    check("flush_lo_q", {32'd0, lo_q}, 64'hA5A5A5A5);

    // stall_m held 4 cycles with an MTHI in W
    drive(2'b10, 64'h55AA55AA_00000000, 1'b0, 1'b0, 1'b0);
    push(2'b10, 64'h55AA55AA_00000000);
    tick();
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 64'd0, 1'b0, 1'b1, 1'b0);
      check("stallm_commit_w", {62'd0, commit_w}, 64'd0);
      check("stallm_hi_e", {32'd0, hi_e}, 64'h55AA55AA);
      check("stallm_hi_q", {32'd0, hi_q}, 64'h12345678);
      tick();
    end
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    check("stallm_release_commit", {62'd0, commit_w}, 64'd2);
    tick();
    check("stallm_hi_q_after", {32'd0, hi_q}, 64'h55AA55AA);
    check("stallm_lo_q_after", {32'd0, lo_q}, 64'hA5A5A5A5);

    // Async reset mid-cycle with MULT in W and MTLO in M
    drive(2'b11, 64'h77777777_88888888, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b01, 64'h00000000_99999999, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    check("arst_hi_e", {32'd0, hi_e}, 64'd0);
    check("arst_lo_e", {32'd0, lo_e}, 64'd0);
    check("arst_hi_q", {32'd0, hi_q}, 64'd0);
    check("arst_lo_q", {32'd0, lo_q}, 64'd0);
    check("arst_commit_w", {62'd0, commit_w}, 64'd0);
    tick();
    rst = 1'b1;

    // Recovery after reset
    drive(2'b10, 64'hCCCCCCCC_00000000, 1'b0, 1'b0, 1'b0);
    push(2'b10, 64'hCCCCCCCC_00000000);
    tick();
    drive(2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("recover_hi_q", {32'd0, hi_q}, 64'hCCCCCCCC);
    check("recover_lo_q", {32'd0, lo_q}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
